// File: rtl/hbi_pkg.sv
// hbi_pkg: shared types and constants for the HBI read prefetch buffer.
// Holds the FSM state enum, the page size, the default FIFO depth and address
// width, and a helper that detects the last dword of a 1K-dword page.
package hbi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } hbi_state_e;

    localparam int HBI_PAGE_DW     = 1024;
    localparam int HBI_DEPTH_DEF   = 8;
    localparam int HBI_ADDR_W_DEF  = 23;
    localparam int HBI_CNT_W_DEF   = $clog2(HBI_DEPTH_DEF) + 1;

    // True when the low ten address bits select the final dword of a page.
    function automatic logic hbi_page_last(input logic [9:0] addr_lo);
        return (addr_lo == 10'(HBI_PAGE_DW - 1));
    endfunction

endpackage

// File: rtl/hbi_sync_fifo.sv
// hbi_sync_fifo: small synchronous FIFO for returned read words.
// Registered storage with fall-through read; the head word is forced to 0
// while the FIFO is empty so downstream logic never sees stale data.
module hbi_sync_fifo
    import hbi_pkg::*;
#(
    parameter int DEPTH = HBI_DEPTH_DEF,
    parameter int DW    = 32
) (
    input  logic                     hb_clk,
    input  logic                     sys_reset_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic [DW-1:0]            wdata,
    input  logic                     pop,
    output logic [DW-1:0]            rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DW-1:0]    mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_s;
    logic             pop_s;
    logic             empty_s;
    logic             full_s;

    // Qualify push/pop against the current occupancy.
    always_comb begin
        empty_s = (count_r == {CNT_W{1'b0}});
        full_s  = (count_r == CNT_W'(DEPTH));
        push_s  = push & ~full_s;
        pop_s   = pop & ~empty_s;
    end

    // Pointer and occupancy tracking; clr empties the FIFO in one cycle.
    always_ff @(posedge hb_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (clr) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    // Word storage; contents need no clearing because the output is masked.
    always_ff @(posedge hb_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DW{1'b0}};
            end
        end else if (push_s && !clr) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Fall-through head word, zero while empty.
    always_comb begin
        if (empty_s) begin
            rdata = {DW{1'b0}};
        end else begin
            rdata = mem_r[rd_ptr_r];
        end
    end

    assign count = count_r;
    assign empty = empty_s;

endmodule

// File: rtl/hbi_rd_prefetch.sv
// hbi_rd_prefetch: host-bus read prefetch buffer ahead of the HBI data-out stage.
// Issues sequential dword reads to the memory controller, buffers returns and
// presents the head word with rd_data_avail. Build option HBI_RD_PREFETCH_EN:
// when defined, up to DEPTH words are fetched ahead; when undefined, only one
// word is ever outstanding and a new request waits for the FIFO to drain.
module hbi_rd_prefetch
    import hbi_pkg::*;
#(
    parameter int DEPTH  = HBI_DEPTH_DEF,
    parameter int ADDR_W = HBI_ADDR_W_DEF
) (
    input  logic              hb_clk,
    input  logic              sys_reset_n,
    input  logic              rd_start,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_flush,
    input  logic              trdy_n,
    input  logic              irdy_n,
    output logic              mc_req,
    output logic [ADDR_W-1:0] mc_req_addr,
    input  logic              mc_ack,
    input  logic              mc_rdata_vld,
    input  logic [31:0]       mc_rdata,
    output logic [31:0]       hb_rcache_dout,
    output logic              rd_data_avail,
    output logic              rd_busy
);

    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int SUM_W  = CNT_W + 1;
    // Stale returns can pile up across repeated flush/restart sequences.
    localparam int DROP_W = CNT_W + 4;
`ifdef HBI_RD_PREFETCH_EN
    localparam int CREDIT_LIM = DEPTH;
`else
    localparam int CREDIT_LIM = 1;
`endif

    hbi_state_e        state_r;
    hbi_state_e        state_nx_s;
    logic              mc_req_r;
    logic              mc_req_nx_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_nx_s;
    logic [CNT_W-1:0]  inflight_r;
    logic [CNT_W-1:0]  inflight_tmp_s;
    logic [CNT_W-1:0]  inflight_nx_s;
    logic [DROP_W-1:0] drop_cnt_r;
    logic [DROP_W-1:0] drop_tmp_s;
    logic [DROP_W-1:0] drop_nx_s;
    logic              busy_r;
    logic              busy_nx_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic [CNT_W-1:0]  fifo_count_nx_s;
    logic              fifo_empty_s;
    logic [31:0]       fifo_dout_s;
    logic [SUM_W-1:0]  credit_sum_s;
    logic              acc_s;
    logic              ret_drop_s;
    logic              ret_keep_s;
    logic              push_s;
    logic              pop_s;
    logic              start_ok_s;

    // Next-state, credit and drop accounting for the request engine.
    always_comb begin
        acc_s      = mc_req_r & mc_ack;
        ret_drop_s = mc_rdata_vld & (drop_cnt_r != {DROP_W{1'b0}});
        ret_keep_s = mc_rdata_vld & (drop_cnt_r == {DROP_W{1'b0}});
        // A return landing in the flush cycle belongs to the old transaction.
        push_s     = ret_keep_s & ~rd_flush;
        pop_s      = ~trdy_n & ~irdy_n & ~fifo_empty_s & ~rd_flush;

        // Returns come back in order, so stale words are consumed first.
        inflight_tmp_s = inflight_r + CNT_W'(acc_s) - CNT_W'(ret_keep_s);
        drop_tmp_s     = drop_cnt_r - DROP_W'(ret_drop_s);
        if (rd_flush) begin
            drop_nx_s       = drop_tmp_s + DROP_W'(inflight_tmp_s);
            inflight_nx_s   = {CNT_W{1'b0}};
            fifo_count_nx_s = {CNT_W{1'b0}};
        end else begin
            drop_nx_s       = drop_tmp_s;
            inflight_nx_s   = inflight_tmp_s;
            fifo_count_nx_s = fifo_count_s + CNT_W'(push_s) - CNT_W'(pop_s);
        end

        start_ok_s = rd_start & ((state_r == IDLE) | rd_flush);

        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (rd_start) begin
                    state_nx_s = FETCH;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            FETCH: begin
                if (rd_flush) begin
                    state_nx_s = rd_start ? FETCH : IDLE;
                end else if (acc_s && hbi_page_last(addr_r[9:0])) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = FETCH;
                end
            end
            DONE: begin
                if (rd_flush) begin
                    state_nx_s = rd_start ? FETCH : IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: state_nx_s = IDLE;
        endcase

        if (start_ok_s) begin
            addr_nx_s = rd_addr;
        end else if (acc_s) begin
            addr_nx_s = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
            addr_nx_s = addr_r;
        end

        credit_sum_s = SUM_W'(fifo_count_nx_s) + SUM_W'(inflight_nx_s);
        mc_req_nx_s  = (state_nx_s == FETCH) && (credit_sum_s < SUM_W'(CREDIT_LIM));
        busy_nx_s    = (state_nx_s != IDLE) || (drop_nx_s != {DROP_W{1'b0}});
    end

    // Request FSM with registered request, address and busy outputs.
    always_ff @(posedge hb_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state_r    <= IDLE;
            mc_req_r   <= 1'b0;
            addr_r     <= {ADDR_W{1'b0}};
            inflight_r <= {CNT_W{1'b0}};
            drop_cnt_r <= {DROP_W{1'b0}};
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            mc_req_r   <= mc_req_nx_s;
            addr_r     <= addr_nx_s;
            inflight_r <= inflight_nx_s;
            drop_cnt_r <= drop_nx_s;
            busy_r     <= busy_nx_s;
        end
    end

    hbi_sync_fifo #(
        .DEPTH (DEPTH),
        .DW    (32)
    ) u_fifo (
        .hb_clk      (hb_clk),
        .sys_reset_n (sys_reset_n),
        .clr         (rd_flush),
        .push        (push_s),
        .wdata       (mc_rdata),
        .pop         (pop_s),
        .rdata       (fifo_dout_s),
        .count       (fifo_count_s),
        .empty       (fifo_empty_s)
    );

    assign mc_req         = mc_req_r;
    assign mc_req_addr    = addr_r;
    assign rd_busy        = busy_r;
    assign rd_data_avail  = ~fifo_empty_s;
    assign hb_rcache_dout = fifo_dout_s;

endmodule

// File: tb/tb_hbi_rd_prefetch.sv
// Self-checking bench for hbi_rd_prefetch with a memory-controller model and
// a scoreboard of expected head words.
module tb_hbi_rd_prefetch;
    import hbi_pkg::*;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 23;
`ifdef HBI_RD_PREFETCH_EN
    localparam int LIM = DEPTH;
`else
    localparam int LIM = 1;
`endif

    logic              hb_clk;
    logic              sys_reset_n;
    logic              rd_start;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_flush;
    logic              trdy_n;
    logic              irdy_n;
    logic              mc_req;
    logic [ADDR_W-1:0] mc_req_addr;
    logic              mc_ack;
    logic              mc_rdata_vld;
    logic [31:0]       mc_rdata;
    logic [31:0]       hb_rcache_dout;
    logic              rd_data_avail;
    logic              rd_busy;

    hbi_rd_prefetch #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .hb_clk         (hb_clk),
        .sys_reset_n    (sys_reset_n),
        .rd_start       (rd_start),
        .rd_addr        (rd_addr),
        .rd_flush       (rd_flush),
        .trdy_n         (trdy_n),
        .irdy_n         (irdy_n),
        .mc_req         (mc_req),
        .mc_req_addr    (mc_req_addr),
        .mc_ack         (mc_ack),
        .mc_rdata_vld   (mc_rdata_vld),
        .mc_rdata       (mc_rdata),
        .hb_rcache_dout (hb_rcache_dout),
        .rd_data_avail  (rd_data_avail),
        .rd_busy        (rd_busy)
    );

    typedef struct {
        int                due;
        logic [ADDR_W-1:0] addr;
        int                ep;
    } ret_t;

    ret_t              ret_q[$];
    logic [31:0]       exp_q[$];
    logic [ADDR_W-1:0] req_log[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ep_cur = 0;
    int pop_cnt = 0;
    int lat = 3;
    bit ack_en = 1'b0;
    bit pop_en = 1'b0;

    initial hb_clk = 1'b0;
    always #5 hb_clk = ~hb_clk;

    function automatic logic [31:0] mk_data(input logic [ADDR_W-1:0] a);
        return {a[7:0] ^ 8'h5A, 1'b0, a};
    endfunction

    // One clock: drive inputs at negedge, update scoreboard, check after posedge.
    task automatic step(input bit do_start, input logic [ADDR_W-1:0] saddr, input bit do_flush);
        ret_t r;
        bit acc, vld, popd;
        int cur_out;
        logic [31:0] exp_head;
        rd_start = do_start;
        rd_addr  = do_start ? saddr : {ADDR_W{1'b0}};
        rd_flush = do_flush;
        trdy_n   = ~pop_en;
        irdy_n   = ~pop_en;
        mc_ack   = ack_en;
        vld = (ret_q.size() > 0) && (ret_q[0].due == cyc);
        if (vld) begin
            r = ret_q.pop_front();
            mc_rdata_vld = 1'b1;
            mc_rdata     = mk_data(r.addr);
        end else begin
            mc_rdata_vld = 1'b0;
            mc_rdata     = 32'hDEAD_BEEF;
        end
        #1;
        acc  = mc_req && ack_en;
        popd = pop_en && rd_data_avail && !do_flush;
        if (popd) begin
            pop_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_word: DUT popped %08h but scoreboard empty", hb_rcache_dout);
            end else begin
                if (hb_rcache_dout !== exp_q[0]) begin
                    errors++;
                    $display("FAIL pop_word: got %08h expected %08h", hb_rcache_dout, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
        if (vld && (r.ep == ep_cur) && !do_flush) exp_q.push_back(mk_data(r.addr));
        if (acc) begin
            ret_q.push_back('{due: cyc + lat, addr: mc_req_addr, ep: ep_cur});
            req_log.push_back(mc_req_addr);
        end
        if (do_flush) begin
            exp_q.delete();
            ep_cur++;
        end
        @(posedge hb_clk);
        #1;
        cyc++;
        exp_head = (exp_q.size() != 0) ? exp_q[0] : 32'h0;
        checks++;
        if (rd_data_avail !== (exp_q.size() != 0)) begin
            errors++;
            $display("FAIL avail: got %b expected %b at cycle %0d", rd_data_avail, (exp_q.size() != 0), cyc);
        end
        checks++;
        if (hb_rcache_dout !== exp_head) begin
            errors++;
            $display("FAIL head: got %08h expected %08h at cycle %0d", hb_rcache_dout, exp_head, cyc);
        end
        cur_out = 0;
        foreach (ret_q[i]) if (ret_q[i].ep == ep_cur) cur_out++;
        checks++;
        if (cur_out + exp_q.size() > LIM) begin
            errors++;
            $display("FAIL credit: buffered+inflight %0d exceeds %0d at cycle %0d", cur_out + exp_q.size(), LIM, cyc);
        end
        @(negedge hb_clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, {ADDR_W{1'b0}}, 1'b0);
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 40 && rd_busy; i++) step(1'b0, {ADDR_W{1'b0}}, 1'b0);
        checks++;
        if (rd_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: rd_busy=%b expected 0", nm, rd_busy);
        end
    endtask

    task automatic test_reset();
        sys_reset_n = 1'b0;
        rd_start = 1'b0; rd_addr = {ADDR_W{1'b0}}; rd_flush = 1'b0;
        trdy_n = 1'b1; irdy_n = 1'b1; mc_ack = 1'b0;
        mc_rdata_vld = 1'b0; mc_rdata = 32'h0;
        repeat (3) @(negedge hb_clk);
        checks++; if (mc_req !== 1'b0) begin errors++; $display("FAIL rst_mc_req: got %b expected 0", mc_req); end
        checks++; if (mc_req_addr !== {ADDR_W{1'b0}}) begin errors++; $display("FAIL rst_addr: got %h expected 0", mc_req_addr); end
        checks++; if (hb_rcache_dout !== 32'h0) begin errors++; $display("FAIL rst_dout: got %h expected 0", hb_rcache_dout); end
        checks++; if (rd_data_avail !== 1'b0) begin errors++; $display("FAIL rst_avail: got %b expected 0", rd_data_avail); end
        checks++; if (rd_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", rd_busy); end
        sys_reset_n = 1'b1;
        @(negedge hb_clk);
    endtask

    task automatic test_prefetch();
        ack_en = 1'b1; pop_en = 1'b0; req_log.delete();
        step(1'b1, 23'h100, 1'b0);
        checks++; if (mc_req !== 1'b1) begin errors++; $display("FAIL start_req: got %b expected 1", mc_req); end
        run(20);
        checks++;
        if (req_log.size() != LIM) begin errors++; $display("FAIL prefetch_cnt: got %0d expected %0d", req_log.size(), LIM); end
        foreach (req_log[i]) begin
            checks++;
            if (req_log[i] !== 23'(23'h100 + i)) begin errors++; $display("FAIL prefetch_addr%0d: got %h expected %h", i, req_log[i], 23'(23'h100 + i)); end
        end
        checks++; if (mc_req !== 1'b0) begin errors++; $display("FAIL credit_stop: mc_req=%b expected 0", mc_req); end
    endtask

    task automatic test_stream();
        int n0;
        n0 = req_log.size();
        pop_en = 1'b1;
        run(40);
        checks++;
        if (req_log.size() <= n0) begin errors++; $display("FAIL refill: requests %0d expected more than %0d", req_log.size(), n0); end
        ack_en = 1'b0;
        run(10);
        pop_en = 1'b0;
        step(1'b0, {ADDR_W{1'b0}}, 1'b1);
        checks++; if (mc_req !== 1'b0) begin errors++; $display("FAIL flush_req: mc_req=%b expected 0", mc_req); end
        wait_idle("stream");
    endtask

    task automatic test_flush_restart();
        int target;
        bit seen;
        target = (LIM >= 5) ? 5 : 1;
        ack_en = 1'b1; pop_en = 1'b0;
        step(1'b1, 23'h180, 1'b0);
        for (int i = 0; i < 30 && exp_q.size() < target; i++) run(1);
        checks++;
        if (exp_q.size() != target) begin errors++; $display("FAIL flush_fill: buffered %0d expected %0d", exp_q.size(), target); end
        step(1'b1, 23'h200, 1'b1);
        checks++; if (mc_req_addr !== 23'h200) begin errors++; $display("FAIL restart_addr: got %h expected 200", mc_req_addr); end
        checks++; if (rd_busy !== 1'b1) begin errors++; $display("FAIL restart_busy: got %b expected 1", rd_busy); end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            run(1);
            seen = rd_data_avail;
        end
        checks++;
        if (!seen || hb_rcache_dout !== mk_data(23'h200)) begin
            errors++; $display("FAIL restart_first: got %08h avail %b expected %08h", hb_rcache_dout, seen, mk_data(23'h200));
        end
        step(1'b0, {ADDR_W{1'b0}}, 1'b1);
        wait_idle("flush");
    endtask

    task automatic test_page_end();
        ack_en = 1'b1; pop_en = 1'b1; req_log.delete();
        step(1'b1, 23'h3FC, 1'b0);
        run(40);
        checks++;
        if (req_log.size() != 4) begin errors++; $display("FAIL page_cnt: got %0d expected 4", req_log.size()); end
        foreach (req_log[i]) begin
            checks++;
            if (req_log[i] !== 23'(23'h3FC + i)) begin errors++; $display("FAIL page_addr%0d: got %h expected %h", i, req_log[i], 23'(23'h3FC + i)); end
        end
        checks++; if (mc_req !== 1'b0) begin errors++; $display("FAIL page_req: got %b expected 0", mc_req); end
        checks++; if (rd_busy !== 1'b1) begin errors++; $display("FAIL page_done_busy: got %b expected 1", rd_busy); end
        pop_en = 1'b0;
        step(1'b0, {ADDR_W{1'b0}}, 1'b1);
        wait_idle("page");
    endtask

    task automatic test_push_pop_full();
        bit hit;
        int exp_drain;
        ack_en = 1'b1; pop_en = 1'b0;
        step(1'b1, 23'h040, 1'b0);
        for (int i = 0; i < 40 && !(exp_q.size() == LIM && ret_q.size() == 0); i++) run(1);
        checks++;
        if (exp_q.size() != LIM) begin errors++; $display("FAIL pp_fill: buffered %0d expected %0d", exp_q.size(), LIM); end
        pop_en = 1'b1; run(1); pop_en = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            hit = (ret_q.size() > 0) && (ret_q[0].due == cyc);
            pop_en = hit;
            if (hit) ack_en = 1'b0;
            run(1);
        end
        pop_en = 1'b0;
        checks++;
        if (!hit) begin errors++; $display("FAIL pp_return: no refill return within bound"); end
        exp_drain = (LIM > 1) ? LIM - 1 : 1;
        pop_cnt = 0;
        pop_en = 1'b1;
        run(LIM + 4);
        pop_en = 1'b0;
        checks++;
        if (pop_cnt != exp_drain) begin errors++; $display("FAIL pp_drain: popped %0d expected %0d", pop_cnt, exp_drain); end
        step(1'b0, {ADDR_W{1'b0}}, 1'b1);
        wait_idle("pp");
    endtask

    task automatic test_mid_reset();
        ack_en = 1'b1; pop_en = 1'b0;
        step(1'b1, 23'h010, 1'b0);
        run(5);
        #2;
        sys_reset_n = 1'b0;
        #1;
        checks++;
        if ({mc_req, rd_data_avail, rd_busy} !== 3'b000 || hb_rcache_dout !== 32'h0 || mc_req_addr !== {ADDR_W{1'b0}}) begin
            errors++;
            $display("FAIL mid_reset: req %b avail %b busy %b dout %h addr %h expected all 0", mc_req, rd_data_avail, rd_busy, hb_rcache_dout, mc_req_addr);
        end
        ret_q.delete(); exp_q.delete(); ep_cur++;
        @(negedge hb_clk);
        sys_reset_n = 1'b1;
        run(3);
        checks++; if (rd_busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b expected 0", rd_busy); end
    endtask

    initial begin
        test_reset();
        test_prefetch();
        test_stream();
        test_flush_restart();
        test_page_end();
        test_push_pop_full();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule

// File: doc/hbi_rd_prefetch.md
# hbi_rd_prefetch

Host-bus read prefetch buffer that sits directly upstream of the HBI data-out stage. It issues sequential dword read requests to the memory controller for memory-window reads and buffers the returned words. It presents the head word as `hb_rcache_dout` and raises `rd_data_avail`, which is OR-ed into `any_trdy_async`. It pops one word per completed PCI data beat.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, 4..32.
- `ADDR_W`, 23: dword address width.
- `hb_clk`  in  1  host bus clock; all logic on rising edge.
- `sys_reset_n`  in  1  asynchronous, active-low reset.
- `rd_start`  in  1  one-cycle pulse that begins a read transaction at `rd_addr`.
- `rd_addr`  in  ADDR_W  starting dword address, sampled with `rd_start`.
- `rd_flush`  in  1  one-cycle pulse that terminates the transaction and discards buffered or in-flight data.
- `trdy_n`  in  1  target ready, active low.
- `irdy_n`  in  1  initiator ready, active low.
- `mc_req`  out  1  read request to the memory controller; level signal.
- `mc_req_addr`  out  ADDR_W  dword address of the current request.
- `mc_ack`  in  1  request accepted; counts only when `mc_req` is also high.
- `mc_rdata_vld`  in  1  return word valid; returns arrive in request order.
- `mc_rdata`  in  32  return word.
- `hb_rcache_dout`  out  32  FIFO head word; 0 when the FIFO is empty.
- `rd_data_avail`  out  1  FIFO non-empty.
- `rd_busy`  out  1  transaction active, or drops still pending.

## Operation
- State machine:
  - IDLE → on `rd_start` → FETCH (load `mc_req_addr`).
  - FETCH → on `rd_flush` → IDLE.
  - FETCH → when the accepted request addresses the last dword of a 1K-dword page (`addr[9:0]==10'h3FF`) → DONE.
  - DONE → on `rd_flush` → IDLE.
- Credit rule: in FETCH, `mc_req` is high only when `fifo_count + inflight < DEPTH`.
  - On `mc_req && mc_ack`: `inflight` increments and `mc_req_addr` increments.
  - On each `mc_rdata_vld`: `inflight` decrements.
  - `mc_req` is registered and recomputed every cycle.
- Push: `mc_rdata_vld` while `drop_cnt == 0` writes `mc_rdata` into the FIFO.
- Drop: `mc_rdata_vld` while `drop_cnt != 0` decrements `drop_cnt`; the word is not written.
- Pop: `!trdy_n && !irdy_n && rd_data_avail` advances the head. A pop while empty is ignored.
- Flush:
  - FIFO is emptied.
  - `drop_cnt <= drop_cnt + inflight` (minus one if a return arrives the same cycle).
  - `inflight <= 0`.
  - `mc_req` deasserts the next cycle. An ack arriving in the flush cycle is added to `drop_cnt`.
- `rd_flush` and `rd_start` in the same cycle: flush applies first, then start loads the new address. Old returns are dropped before new ones are buffered.
- Simultaneous push and pop: count unchanged. A push when full is impossible by the credit rule; the bench asserts this.
- `rd_busy` = state != IDLE or `drop_cnt != 0`.
- Reset mid-transaction: all counters, pointers and state clear immediately. Returns after reset are not tracked; the memory controller is reset by the same `sys_reset_n`.

## Timing
- Reset values: `mc_req`=0, `mc_req_addr`=0, `hb_rcache_dout`=0, `rd_data_avail`=0, `rd_busy`=0.
- `rd_start` at cycle N → `mc_req` high at N+1.
- `mc_rdata_vld` at cycle M → `rd_data_avail` high and `hb_rcache_dout` valid at M+1.
- Pop at cycle P → next head word (or 0 / `rd_data_avail` low) at P+1.
- `rd_flush` at cycle F → `rd_data_avail` low and `mc_req` low at F+1.

## Configuration
- `HBI_RD_PREFETCH_EN` defined: credit limit is DEPTH, so up to DEPTH words are speculatively fetched ahead.
- Undefined: credit limit is 1. `mc_req` rises only when the FIFO is empty and `inflight == 0`, giving single-word, non-speculative reads; same ports and timing.

## Structure
- `hbi_pkg`:
  - state enum `{IDLE, FETCH, DONE}`
  - `HBI_PAGE_DW = 1024`
  - `DEPTH` default
  - counter width `$clog2(DEPTH)+1`
- Sub-module `hbi_sync_fifo`: storage, read/write pointers and count. Its read port is registered-array fall-through and its output is masked to 0 when empty.

## Test plan
- Reset, then `rd_start`, `rd_addr`=0x100, `mc_ack` tied high, each return 3 cycles after ack → requests 0x100..0x107 issued, `mc_req` drops at 8 credits, `rd_data_avail` rises 1 cycle after first return.
- Continuous beats (`trdy_n`=`irdy_n`=0) → `hb_rcache_dout` sequence equals returned words in order; refill requests resume as entries pop.
- Flush with 5 buffered and 3 in flight, immediate `rd_start` at 0x200 → 3 stale returns dropped, first buffered word is data for 0x200.
- `rd_addr`=0x3FC → exactly 4 requests (0x3FC..0x3FF); state DONE; no further `mc_req`.
- Push and pop in the same cycle with the FIFO at 7 → count stays 7, no overflow; assert no push when full.
- Build without `HBI_RD_PREFETCH_EN` → never more than 1 in flight; `mc_req` waits for the FIFO to empty.
